// File: rtl/proc_ctrl_core_pkg.sv
// Shared definitions for the simple processor core.
// Holds the opcode values, the sequencer state encoding and the shared-bus
// source selects used by proc_ctrl_core.
package proc_ctrl_core_pkg;

    // Opcodes, IR[8:6]; any value with bit 2 set is a nop.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Sequencer time steps.
    typedef enum logic [1:0] {
        StT0,
        StT1,
        StT2,
        StT3
    } state_e;

    // Shared bus sources.
    typedef enum logic [1:0] {
        BusDin,
        BusRx,
        BusRy,
        BusG
    } bus_sel_e;

endpackage

// File: rtl/proc_regn.sv
// Generic load-enable register with asynchronous active-low clear.
// Used for the general registers R0..R7, the alu operand A, the result G and IR.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low clear
//   en_i    load enable
//   d_i     data in
//   q_o     registered data out
module proc_regn #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/proc_ctrl_core.sv
// Instruction sequencer and datapath of the simple processor.
// Fetches a 9-bit instruction (III XXX YYY) from DIN, moves operands over a
// single shared bus, runs add/sub through the alu stage and writes results back
// into an 8-entry register file. Done pulses in the last cycle of every instruction.
// Ports:
//   CLOCK_50  system clock, rising edge
//   Resetn    asynchronous active-low reset
//   Run       start request, only looked at in T0
//   DIN       instruction word in T0, immediate in T1 of mvi
//   Done      high during the final cycle of each instruction
//   BusWires  current value of the shared bus
//   dbg_sel   debug register select
//   dbg_data  combinational read of register dbg_sel
module proc_ctrl_core
    import proc_ctrl_core_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e state_q, state_d;
    bus_sel_e bus_sel;

    logic [8:0]        ir_q;
    logic [DATA_W-1:0] a_q, g_q, alu_res;
    logic [DATA_W-1:0] r_q [NREGS];
    logic [NREGS-1:0]  r_en;
    logic              ir_en, a_en, g_en, wr_en;

    logic [2:0] op, rx_sel, ry_sel;

    assign op     = ir_q[8:6];
    assign rx_sel = ir_q[5:3];
    assign ry_sel = ir_q[2:0];

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bus_sel = BusDin;
        ir_en   = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        wr_en   = 1'b0;
        Done    = 1'b0;
        case (state_q)
            StT0: begin
                ir_en = Run;
                if (Run) begin
                    state_d = StT1;
                end
            end
            StT1: begin
                state_d = StT0;
                case (op)
                    OP_MV: begin
                        bus_sel = BusRy;
                        wr_en   = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = BusDin;
                        wr_en   = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = BusRx;
                        a_en    = 1'b1;
                        state_d = StT2;
                    end
                    default: begin
                        // nop: finish without touching any register
                        Done = 1'b1;
                    end
                endcase
            end
            StT2: begin
                bus_sel = BusRy;
                g_en    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                bus_sel = BusG;
                wr_en   = 1'b1;
                Done    = 1'b1;
                state_d = StT0;
            end
            default: state_d = StT0;
        endcase
    end

    always_comb begin
        unique case (bus_sel)
            BusDin:  BusWires = DIN;
            BusRx:   BusWires = r_q[rx_sel];
            BusRy:   BusWires = r_q[ry_sel];
            BusG:    BusWires = g_q;
            default: BusWires = DIN;
        endcase
    end

    // alu: IR[6] selects subtract; results wrap modulo 2^DATA_W
    assign alu_res = ir_q[6] ? (a_q - BusWires) : (a_q + BusWires);

    assign r_en     = wr_en ? (NREGS'(1) << rx_sel) : '0;
    assign dbg_data = r_q[dbg_sel];

    proc_regn #(.W(9)) u_ir (
        .clk_i  (CLOCK_50),
        .rst_ni (Resetn),
        .en_i   (ir_en),
        .d_i    (DIN[8:0]),
        .q_o    (ir_q)
    );

    proc_regn #(.W(DATA_W)) u_a (
        .clk_i  (CLOCK_50),
        .rst_ni (Resetn),
        .en_i   (a_en),
        .d_i    (BusWires),
        .q_o    (a_q)
    );

    proc_regn #(.W(DATA_W)) u_g (
        .clk_i  (CLOCK_50),
        .rst_ni (Resetn),
        .en_i   (g_en),
        .d_i    (alu_res),
        .q_o    (g_q)
    );

    for (genvar i = 0; i < NREGS; i++) begin : g_regs
        proc_regn #(.W(DATA_W)) u_r (
            .clk_i  (CLOCK_50),
            .rst_ni (Resetn),
            .en_i   (r_en[i]),
            .d_i    (BusWires),
            .q_o    (r_q[i])
        );
    end

endmodule
